// File: rtl/bsr_dma_engine.sv
// UART-fed loader for block-sparse (BSR) weight layers: parses layer/header,
// streams row_ptr/col_idx/block payload into BRAM ports, verifies CRC32.
module bsr_dma_engine #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int MAX_LAYERS    = 8,
  parameter int MAX_BLOCKS    = 65536,
  parameter int BLOCK_SIZE    = 64,
  parameter int ROW_PTR_DEPTH = 256,
  parameter int COL_IDX_DEPTH = 65536,
  parameter int ENABLE_CRC    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  csr_addr,
  input  logic        csr_wen,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        row_ptr_we,
  output logic [15:0] row_ptr_waddr,
  output logic [31:0] row_ptr_wdata,
  output logic        col_idx_we,
  output logic [15:0] col_idx_waddr,
  output logic [15:0] col_idx_wdata,
  output logic        block_we,
  output logic [20:0] block_waddr,
  output logic [31:0] block_wdata,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_error,
  output logic [31:0] blocks_written,
  output logic [31:0] dma_meta_data,
  output logic [7:0]  dma_meta_waddr,
  output logic [1:0]  dma_meta_type,
  output logic        dma_meta_wen,
  input  logic        dma_meta_ready
);
  typedef enum logic [3:0] {
    S_IDLE, S_LAYER, S_HDR, S_ROWPTR, S_COLIDX, S_BLOCK, S_CRC, S_DONE, S_ERR
  } state_e;

  localparam int          BS_LOG2  = $clog2(BLOCK_SIZE);
  localparam logic [31:0] MAXL     = 32'(MAX_LAYERS);
  localparam logic [31:0] RPD      = 32'(ROW_PTR_DEPTH);
  localparam logic [31:0] MAXB     = 32'(MAX_BLOCKS);
  localparam logic [31:0] CID      = 32'(COL_IDX_DEPTH);
  localparam logic [21:0] BLK_MASK = 22'(BLOCK_SIZE - 1);

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[31] ^ d[i]) ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [2:0]            layer_q, layer_d;
  logic                  wmode_q, wmode_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [31:0]           blocks_q, blocks_d, crc_q, crc_d, sr_q, sr_d;
  logic [31:0]           rows_q, rows_d, cols_q, cols_d, total_q, total_d;
  logic [1:0]            bcnt_q, bcnt_d, ptype_q, ptype_d;
  logic [21:0]           idx_q, idx_d;
  logic                  pend_q, pend_d, bwe_q, bwe_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]           pdata_q, pdata_d, bdata_q, bdata_d;
  logic [20:0]           baddr_q, baddr_d;

  logic        rx_fire, start;
  logic [31:0] sr_nxt, blk_last;
  logic        unused_ok;

  // A meta write waiting on dma_meta_ready back-pressures the byte stream
  assign uart_rx_ready = (state_q >= S_LAYER) && (state_q <= S_CRC) &&
                         !(pend_q && !dma_meta_ready);
  assign rx_fire  = uart_rx_valid && uart_rx_ready;
  assign start    = (state_q == S_IDLE) && csr_wen && (csr_addr == 8'h51) && csr_wdata[0];
  assign sr_nxt   = {uart_rx_data, sr_q[31:DATA_WIDTH]};
  assign blk_last = (total_q << BS_LOG2) - 32'd1;
  assign unused_ok = ^{csr_wdata[31:3], csr_wdata[1], sr_q[DATA_WIDTH-1:0]};

  always_comb begin
    state_d = state_q;  layer_d = layer_q;  wmode_d = wmode_q;
    busy_d  = busy_q;   done_d  = done_q;   err_d   = err_q;
    blocks_d = blocks_q; crc_d = crc_q; sr_d = sr_q; bcnt_d = bcnt_q; idx_d = idx_q;
    rows_d = rows_q; cols_d = cols_q; total_d = total_q;
    pend_d = pend_q && !dma_meta_ready;
    ptype_d = ptype_q; paddr_d = paddr_q; pdata_d = pdata_q;
    bwe_d = 1'b0; baddr_d = baddr_q; bdata_d = bdata_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LAYER; busy_d = 1'b1; done_d = 1'b0; err_d = 1'b0;
        blocks_d = '0; crc_d = '1; wmode_d = csr_wdata[2]; idx_d = '0; bcnt_d = '0;
      end
      S_LAYER: if (rx_fire) begin
        if ({24'd0, uart_rx_data} < MAXL) begin
          layer_d = uart_rx_data[2:0]; state_d = S_HDR;
        end else state_d = S_ERR;
      end
      S_HDR: if (rx_fire) begin
        sr_d = sr_nxt; idx_d = idx_q + 22'd1;
        if (idx_q[1:0] == 2'd3)
          case (idx_q[3:2])
            2'd0:    rows_d  = sr_nxt;
            2'd1:    cols_d  = sr_nxt;
            default: total_d = sr_nxt;
          endcase
        if (idx_q == 22'd11) begin
          idx_d = '0; bcnt_d = '0;
          if (rows_q >= RPD || sr_nxt > MAXB || sr_nxt > CID || sr_nxt == 32'd0) state_d = S_ERR;
          else state_d = S_ROWPTR;
        end
      end
      S_ROWPTR: if (rx_fire) begin
        sr_d = sr_nxt; bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          pend_d = 1'b1; ptype_d = 2'b00; paddr_d = idx_q[ADDR_WIDTH-1:0]; pdata_d = sr_nxt;
          idx_d = idx_q + 22'd1;
          if ({10'd0, idx_q} == rows_q) begin state_d = S_COLIDX; idx_d = '0; end
        end
      end
      S_COLIDX: if (rx_fire) begin
        sr_d = sr_nxt; bcnt_d = bcnt_q ^ 2'd1;
        if (bcnt_q[0]) begin
          bcnt_d = '0;
          if ({16'd0, sr_nxt[31:16]} >= cols_q) state_d = S_ERR;
          else begin
            pend_d = 1'b1; ptype_d = 2'b01; paddr_d = idx_q[ADDR_WIDTH-1:0];
            pdata_d = {16'd0, sr_nxt[31:16]}; idx_d = idx_q + 22'd1;
            if ({10'd0, idx_q} == total_q - 32'd1) begin state_d = S_BLOCK; idx_d = '0; end
          end
        end
      end
      S_BLOCK: if (rx_fire) begin
        crc_d = crc_byte(crc_q, uart_rx_data); sr_d = sr_nxt; idx_d = idx_q + 22'd1;
        if (wmode_q) begin
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin bwe_d = 1'b1; baddr_d = {1'b0, idx_q[21:2]}; bdata_d = sr_nxt; end
        end else begin
          bwe_d = 1'b1; baddr_d = idx_q[20:0]; bdata_d = {24'd0, uart_rx_data};
        end
        if ((idx_q & BLK_MASK) == BLK_MASK && blocks_q != '1) blocks_d = blocks_q + 32'd1;
        if ({10'd0, idx_q} == blk_last) begin
          idx_d = '0; bcnt_d = '0;
          state_d = (ENABLE_CRC != 0) ? S_CRC : S_DONE;
        end
      end
      S_CRC: if (rx_fire) begin
        sr_d = sr_nxt; bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = (sr_nxt == ~crc_q) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: if (uart_tx_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE && state_q != S_DONE) begin busy_d = 1'b0; done_d = 1'b1; end
    if (state_d == S_ERR  && state_q != S_ERR)  begin busy_d = 1'b0; err_d  = 1'b1; end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; layer_q <= '0; wmode_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
      blocks_q <= '0; crc_q <= '0; sr_q <= '0; bcnt_q <= '0; idx_q <= '0;
      rows_q <= '0; cols_q <= '0; total_q <= '0;
      pend_q <= 1'b0; ptype_q <= '0; paddr_q <= '0; pdata_q <= '0;
      bwe_q <= 1'b0; baddr_q <= '0; bdata_q <= '0;
    end else begin
      state_q <= state_d; layer_q <= layer_d; wmode_q <= wmode_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
      blocks_q <= blocks_d; crc_q <= crc_d; sr_q <= sr_d; bcnt_q <= bcnt_d; idx_q <= idx_d;
      rows_q <= rows_d; cols_q <= cols_d; total_q <= total_d;
      pend_q <= pend_d; ptype_q <= ptype_d; paddr_q <= paddr_d; pdata_q <= pdata_d;
      bwe_q <= bwe_d; baddr_q <= baddr_d; bdata_q <= bdata_d;
    end
  end

  // BRAM strobe fires only in the cycle the mirror accepts, so it stays single-cycle
  assign row_ptr_we     = pend_q && dma_meta_ready && (ptype_q == 2'b00);
  assign col_idx_we     = pend_q && dma_meta_ready && (ptype_q == 2'b01);
  assign row_ptr_waddr  = 16'(paddr_q);
  assign row_ptr_wdata  = pdata_q;
  assign col_idx_waddr  = 16'(paddr_q);
  assign col_idx_wdata  = pdata_q[15:0];
  assign dma_meta_wen   = pend_q;
  assign dma_meta_type  = ptype_q;
  assign dma_meta_waddr = paddr_q[7:0];
  assign dma_meta_data  = pdata_q;
  assign block_we       = bwe_q;
  assign block_waddr    = baddr_q;
  assign block_wdata    = bdata_q;

  assign uart_tx_valid  = (state_q == S_DONE) || (state_q == S_ERR);
  assign uart_tx_data   = (state_q == S_DONE) ? 8'h06 : 8'h15;
  assign dma_busy       = busy_q;
  assign dma_done       = done_q;
  assign dma_error      = err_q;
  assign blocks_written = blocks_q;

  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      8'h50:   csr_rdata = {29'd0, layer_q};
      8'h52:   csr_rdata = blocks_q;
      8'h53:   csr_rdata = {29'd0, err_q, done_q, busy_q};
      default: csr_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_bsr_dma_engine.sv
// Randomized scoreboard bench for bsr_dma_engine: a transfer-level model queues
// expected BRAM/meta/TX traffic; a monitor pops and compares as the DUT emits it.
module tb_bsr_dma_engine;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_valid = 1'b0, uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready = 1'b1;
  logic [7:0]  csr_addr = '0;
  logic        csr_wen = 1'b0;
  logic [31:0] csr_wdata = '0, csr_rdata;
  logic        row_ptr_we, col_idx_we, block_we;
  logic [15:0] row_ptr_waddr, col_idx_waddr, col_idx_wdata;
  logic [31:0] row_ptr_wdata, block_wdata, blocks_written, dma_meta_data;
  logic [20:0] block_waddr;
  logic        dma_busy, dma_done, dma_error, dma_meta_wen, dma_meta_ready = 1'b1;
  logic [7:0]  dma_meta_waddr;
  logic [1:0]  dma_meta_type;

  bsr_dma_engine dut (
    .clk(clk), .rst_n(rst_n),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
    .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .row_ptr_we(row_ptr_we), .row_ptr_waddr(row_ptr_waddr), .row_ptr_wdata(row_ptr_wdata),
    .col_idx_we(col_idx_we), .col_idx_waddr(col_idx_waddr), .col_idx_wdata(col_idx_wdata),
    .block_we(block_we), .block_waddr(block_waddr), .block_wdata(block_wdata),
    .dma_busy(dma_busy), .dma_done(dma_done), .dma_error(dma_error),
    .blocks_written(blocks_written),
    .dma_meta_data(dma_meta_data), .dma_meta_waddr(dma_meta_waddr), .dma_meta_type(dma_meta_type),
    .dma_meta_wen(dma_meta_wen), .dma_meta_ready(dma_meta_ready)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0;
  logic [47:0] q_row[$];
  logic [31:0] q_col[$];
  logic [52:0] q_blk[$];
  logic [41:0] q_meta[$];
  logic [7:0]  q_tx[$];
  int          stall_cnt = 0;
  bit          rand_hs = 1'b0;
  logic [2:0]  exp_layer = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] crc_model(input logic [7:0] d[$]);
    logic [31:0] c;
    logic [7:0]  v;
    bit          fb;
    c = 32'hFFFF_FFFF;
    foreach (d[k]) begin
      v = d[k];
      for (int j = 0; j < 8; j++) begin
        fb = c[31] ^ v[j];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C1_1DB7;
      end
    end
    return ~c;
  endfunction

  // handshake drivers: change only on the falling edge
  initial forever begin
    @(negedge clk);
    if (stall_cnt > 0) begin dma_meta_ready = 1'b0; stall_cnt--; end
    else dma_meta_ready = rand_hs ? ($urandom % 4 != 0) : 1'b1;
    uart_tx_ready = rand_hs ? ($urandom % 3 != 0) : 1'b1;
  end

  // monitor: samples mid-cycle, pops expectations as strobes appear
  initial forever begin
    @(negedge clk); #2;
    if (row_ptr_we | col_idx_we | block_we)
      chk("strobes exclusive", 64'($countones({row_ptr_we, col_idx_we, block_we})), 64'd1);
    if (row_ptr_we) begin
      if (q_row.size() == 0) chk("unexpected row_ptr write", {row_ptr_waddr, row_ptr_wdata}, 64'd0 - 1);
      else chk("row_ptr write", {row_ptr_waddr, row_ptr_wdata}, q_row.pop_front());
    end
    if (col_idx_we) begin
      if (q_col.size() == 0) chk("unexpected col_idx write", {col_idx_waddr, col_idx_wdata}, 64'd0 - 1);
      else chk("col_idx write", {col_idx_waddr, col_idx_wdata}, q_col.pop_front());
    end
    if (block_we) begin
      if (q_blk.size() == 0) chk("unexpected block write", {block_waddr, block_wdata}, 64'd0 - 1);
      else chk("block write", {block_waddr, block_wdata}, q_blk.pop_front());
    end
    if (dma_meta_wen && dma_meta_ready) begin
      if (q_meta.size() == 0) chk("unexpected meta write", {dma_meta_type, dma_meta_waddr, dma_meta_data}, 64'd0 - 1);
      else chk("meta write", {dma_meta_type, dma_meta_waddr, dma_meta_data}, q_meta.pop_front());
    end
    if (dma_meta_wen && !dma_meta_ready) chk("rx stalled on meta", uart_rx_ready, 0);
    if (uart_tx_valid && uart_tx_ready) begin
      if (q_tx.size() == 0) chk("unexpected tx byte", uart_tx_data, 64'd0 - 1);
      else chk("tx byte", uart_tx_data, q_tx.pop_front());
    end
  end

  task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); csr_addr = a; csr_wdata = d; csr_wen = 1'b1;
    @(posedge clk); #1; csr_wen = 1'b0; csr_wdata = '0;
  endtask

  task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
    csr_addr = a; #1; d = csr_rdata;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    if (rand_hs) repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk); uart_rx_valid = 1'b1; uart_rx_data = b; #1;
    while (!uart_rx_ready && n < 300) begin @(negedge clk); #1; n++; end
    if (!uart_rx_ready) begin
      checks++;
      $display("FAIL rx accept timeout: byte 0x%0h not accepted in %0d cycles", b, n);
      uart_rx_valid = 1'b0;
    end else begin
      @(posedge clk); #1; uart_rx_valid = 1'b0;
    end
  endtask

  task automatic do_abort();
    logic [31:0] r;
    @(negedge clk); rst_n = 1'b0;
    q_row.delete(); q_col.delete(); q_blk.delete(); q_meta.delete(); q_tx.delete();
    exp_layer = '0;
    #1;
    chk("reset status flags", {dma_busy, dma_done, dma_error, uart_rx_ready, uart_tx_valid}, 0);
    chk("reset blocks_written", blocks_written, 0);
    csr_read(8'h53, r); chk("reset csr status", r, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1; csr_read(8'h50, r); chk("layer after reset", r, 0);
  endtask

  // kind: 0 good, 1 bad layer, 2 bad header, 3 bad col_idx, 4 bad CRC
  task automatic run_xfer(input bit wm, input int lay, input int rows, input int cols,
                          input int total, input int kind, input bit directed,
                          input bit stall, input int abort_at);
    logic [7:0]  s[$];
    logic [7:0]  blk[$];
    logic [31:0] w, r;
    int          exp_blocks, bad_at, c, n;
    bit          err;
    exp_blocks = 0; err = 1'b0;
    bad_at = (kind == 3) ? int'($urandom_range(0, total - 1)) : -1;
    csr_write(8'h51, {29'd0, wm, 2'b01});
    chk("busy after start", {dma_busy, dma_done, dma_error}, 3'b100);
    s.push_back(8'(lay));
    if (kind == 1) err = 1'b1;
    else begin
      exp_layer = 3'(lay);
      w = 32'(rows);  for (int k = 0; k < 4; k++) s.push_back(8'(w >> (8 * k)));
      w = 32'(cols);  for (int k = 0; k < 4; k++) s.push_back(8'(w >> (8 * k)));
      w = 32'(total); for (int k = 0; k < 4; k++) s.push_back(8'(w >> (8 * k)));
      if (kind == 2) err = 1'b1;
      else begin
        for (int i = 0; i <= rows; i++) begin
          w = directed ? 32'(i) : $urandom();
          for (int k = 0; k < 4; k++) s.push_back(8'(w >> (8 * k)));
          q_row.push_back({16'(i), w});
          q_meta.push_back({2'b00, 8'(i), w});
        end
        for (int i = 0; i < total && !err; i++) begin
          if (i == bad_at) begin c = cols + int'($urandom_range(0, 3)); err = 1'b1; end
          else c = directed ? 0 : int'($urandom_range(0, cols - 1));
          s.push_back(8'(c)); s.push_back(8'(c >> 8));
          if (!err) begin
            q_col.push_back({16'(i), 16'(c)});
            q_meta.push_back({2'b01, 8'(i), 32'(c)});
          end
        end
        if (!err) begin
          for (int i = 0; i < total * 64; i++) begin
            blk.push_back(directed ? 8'(16 + i) : 8'($urandom));
            s.push_back(blk[i]);
          end
          if (wm) for (int j = 0; j < total * 16; j++)
            q_blk.push_back({21'(j), blk[4*j+3], blk[4*j+2], blk[4*j+1], blk[4*j]});
          else for (int j = 0; j < total * 64; j++)
            q_blk.push_back({21'(j), 24'd0, blk[j]});
          exp_blocks = total;
          w = crc_model(blk);
          if (kind == 4) begin w[7:0] = ~w[7:0]; err = 1'b1; end
          for (int k = 0; k < 4; k++) s.push_back(8'(w >> (8 * k)));
        end
      end
    end
    q_tx.push_back(err ? 8'h15 : 8'h06);

    for (int i = 0; i < s.size(); i++) begin
      if (abort_at > 0 && i == abort_at) begin do_abort(); return; end
      if (stall && i == 16) stall_cnt = 5;
      if (!directed && !stall && i == s.size() / 2) csr_write(8'h51, 32'h1);
      send_byte(s[i]);
      if (i == 1 && kind != 1) begin csr_read(8'h50, r); chk("layer csr", r, 32'(lay)); end
      if (stall && i == 16) begin
        chk("meta held, rx stalled", {dma_meta_wen, uart_rx_ready, dma_meta_type}, 4'b1000);
        repeat (2) @(posedge clk); #1;
        chk("meta still held", {dma_meta_wen, uart_rx_ready, row_ptr_we}, 3'b100);
      end
    end
    n = 0;
    while (q_tx.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("transfer reaches tx", q_tx.size(), 0);
    @(negedge clk); #1;
    csr_read(8'h53, r); chk("final status", r, err ? 32'h4 : 32'h2);
    csr_read(8'h52, r); chk("csr blocks_written", r, 32'(exp_blocks));
    chk("blocks_written port", blocks_written, 32'(exp_blocks));
    csr_read(8'h50, r); chk("final layer", r, 32'(exp_layer));
    chk("all writes seen", q_row.size() + q_col.size() + q_blk.size() + q_meta.size(), 0);
    chk("rx idle after end", uart_rx_ready, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int kind, rows, cols, total, lay;
    repeat (3) @(negedge clk);
    #1;
    csr_read(8'h53, r); chk("reset csr status", r, 0);
    chk("reset outputs", {uart_rx_ready, dma_busy, uart_tx_valid, dma_meta_wen, block_we}, 0);
    chk("reset blocks_written", blocks_written, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_xfer(1'b1, 2, 1, 1, 1, 0, 1'b1, 1'b0, 0);   // canonical word-mode load
    run_xfer(1'b1, 2, 1, 1, 1, 4, 1'b1, 1'b0, 0);   // corrupted CRC
    run_xfer(1'b1, 9, 1, 1, 1, 1, 1'b1, 1'b0, 0);   // out-of-range layer
    run_xfer(1'b1, 3, 2, 2, 1, 0, 1'b0, 1'b1, 0);   // meta back-pressure in ROWPTR
    run_xfer(1'b0, 5, 1, 1, 1, 0, 1'b1, 1'b0, 0);   // byte mode

    rand_hs = 1'b1;
    for (int t = 0; t < 10; t++) begin
      case ($urandom % 10)
        0: kind = 1;
        1: kind = 2;
        2: kind = 3;
        3: kind = 4;
        default: kind = 0;
      endcase
      rows  = $urandom_range(0, 3);
      cols  = $urandom_range(1, 4);
      total = $urandom_range(1, 2);
      lay   = (kind == 1) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 7));
      if (kind == 2) begin if ($urandom % 2) rows = 256; else total = 0; end
      run_xfer(1'($urandom), lay, rows, cols, total, kind, 1'b0, 1'b0, 0);
    end

    run_xfer(1'b1, 4, 2, 3, 2, 0, 1'b0, 1'b0, 40);  // reset mid-transfer
    run_xfer(1'b0, 6, 1, 2, 1, 0, 1'b0, 1'b0, 0);   // recovery after reset

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/bsr_dma_engine.md
BSR_DMA_ENGINE -- requirements
Module: bsr_dma_engine

Interface
REQ-001 SHALL take parameters: DATA_WIDTH=8 (UART byte width); ADDR_WIDTH=16 (metadata address width); MAX_LAYERS=8 (layer ids 0..7); MAX_BLOCKS=65536 (block limit); BLOCK_SIZE=64 (bytes per 8x8 INT8 block); ROW_PTR_DEPTH=256; COL_IDX_DEPTH=65536; ENABLE_CRC=1 (CRC32 check enabled).
REQ-002 SHALL use one clock and an asynchronous active-low reset: clk in 1 (system clock); rst_n in 1 (async reset, active low).
REQ-003 SHALL provide UART RX: uart_rx_data in 8; uart_rx_valid in 1; uart_rx_ready out 1 (byte accepted when valid&&ready at a clk edge).
REQ-004 SHALL provide UART TX: uart_tx_data out 8; uart_tx_valid out 1; uart_tx_ready in 1.
REQ-005 SHALL provide CSR: csr_addr in 8; csr_wen in 1; csr_wdata in 32; csr_rdata out 32 (combinational decode of csr_addr).
REQ-006 SHALL provide row_ptr BRAM port: row_ptr_we out 1; row_ptr_waddr out 16; row_ptr_wdata out 32.
REQ-007 SHALL provide col_idx BRAM port: col_idx_we out 1; col_idx_waddr out 16; col_idx_wdata out 16.
REQ-008 SHALL provide block BRAM port: block_we out 1; block_waddr out 21; block_wdata out 32.
REQ-009 SHALL provide status outputs: dma_busy, dma_done, dma_error out 1 each; blocks_written out 32.
REQ-010 SHALL provide metadata mirror: dma_meta_data out 32; dma_meta_waddr out 8; dma_meta_type out 2 (00 ROW_PTR, 01 COL_IDX, 10 BLOCK_HDR); dma_meta_wen out 1; dma_meta_ready in 1.

Function
REQ-011 CSR map SHALL be: 0x50 layer (rd [2:0]); 0x51 control (wr bit0 START self-clearing, bit2 WORD_MODE); 0x52 blocks_written; 0x53 status {bit2 error, bit1 done, bit0 busy}; other addresses read 0.
REQ-012 START SHALL move IDLE->LAYER, set busy, clear done/error/blocks_written/CRC, latch WORD_MODE; START while busy SHALL be ignored.
REQ-013 FSM SHALL be: IDLE, LAYER, HDR, ROWPTR, COLIDX, BLOCK, CRC, DONE, ERR; uart_rx_ready=1 in LAYER..CRC only, 0 in IDLE/DONE/ERR or while a meta write is stalled.
REQ-014 LAYER: one byte; value<MAX_LAYERS latched as layer, else ERR.
REQ-015 HDR: 12 bytes, three little-endian 32-bit words num_block_rows, num_block_cols, total_blocks; rows+1>ROW_PTR_DEPTH or total_blocks>MAX_BLOCKS or total_blocks==0 -> ERR.
REQ-016 ROWPTR: rows+1 little-endian 32-bit words; each completed word SHALL pulse row_ptr_we one cycle the clock after its 4th byte, waddr=word index, wdata=word.
REQ-017 COLIDX: total_blocks little-endian 16-bit words; each SHALL pulse col_idx_we with waddr=index; value>=num_block_cols -> ERR.
REQ-018 Each row_ptr/col_idx write SHALL also pulse dma_meta_wen same cycle with data zero-extended, waddr=index[7:0], type 00/01; if dma_meta_ready=0 the write SHALL hold and RX SHALL stall until accepted.
REQ-019 BLOCK: total_blocks*64 bytes; WORD_MODE=1: every 4 bytes pack little-endian (first byte in [7:0]), block_we pulse, block_waddr=byte_offset>>2; WORD_MODE=0: each byte written in wdata[7:0], upper bits 0, block_waddr=byte_offset.
REQ-020 blocks_written SHALL increment after each 64th byte of a block; saturating at 2^32-1.
REQ-021 CRC32 SHALL cover block bytes only: init FFFFFFFF, per byte 8 steps LSB-first, if (c[31]^d[0]) c=(c<<1)^04C11DB7 else c<<=1, d>>=1; final value inverted.
REQ-022 CRC state: 4 bytes LSB-first; match -> DONE, mismatch -> ERR; ENABLE_CRC=0 skips CRC (BLOCK->DONE).
REQ-023 DONE: busy=0, done=1, send 0x06 on TX; ERR: busy=0, error=1, send 0x15; TX byte held until uart_tx_ready; both return to IDLE-equivalent awaiting START, flags sticky until next START.
REQ-024 All write strobes SHALL be single-cycle and never simultaneous with each other.

Reset
REQ-025 rst_n low SHALL immediately force IDLE; all strobes, valid, busy/done/error, blocks_written, layer, WORD_MODE, counters, csr-visible regs =0; uart_rx_ready=0; reset mid-transfer SHALL abandon transfer with no further writes.

Verification
REQ-026 After reset, read 0x53 -> 0x0; uart_rx_ready=0.
REQ-027 Write 0x51=0x5 -> dma_busy=1 within 2 cycles; send 0x02; read 0x50 -> 2.
REQ-028 Header rows=1, cols=1, blocks=1; row_ptr 0x00000000, 0x00000001; col_idx 0 -> row_ptr writes (0,0),(1,1), col_idx write (0,0), two meta pulses types 00 then 01.
REQ-029 64 bytes 0x10..0x4F, WORD_MODE=1 -> 16 block writes, first addr 0 data 0x13121110, last addr 15 data 0x4F4E4D4C; blocks_written=1; correct CRC -> done=1, TX 0x06.
REQ-030 Same with CRC byte corrupted -> error=1, done=0, TX 0x15; layer byte 0x09 -> ERR immediately.
REQ-031 dma_meta_ready held 0 for 5 cycles during ROWPTR -> dma_meta_wen held, uart_rx_ready=0, no data loss.
